// File: rtl/hand_allocator_if.sv
// Player-side bus of the hand allocator: allocation handshake, release strobe and pool status.
interface hand_allocator_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned ADDR_W    = 10
);
  localparam int unsigned CntW = $clog2(NUM_SLOTS + 1);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [ADDR_W-1:0]  address;
  logic               free_valid;
  logic [ADDR_W-1:0]  free_addr;
  logic               free_err;
  logic               full;
  logic [CntW-1:0]    free_count;

  modport master (
    output req, free_valid, free_addr,
    input  ack, address, free_err, full, free_count
  );

  modport slave (
    input  req, free_valid, free_addr,
    output ack, address, free_err, full, free_count
  );
endinterface

// File: rtl/hand_allocator.sv
// Hand-region allocator: arbitrates player requests and scans a free-slot bitmap one slot per cycle.
// Define HAND_ALLOC_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module hand_allocator #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned SLOT_SIZE = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  hand_allocator_if.slave       alloc_io
);
  localparam int unsigned SlotW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned ReqW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW      = $clog2(NUM_SLOTS + 1);
  localparam int unsigned SlotShift = $clog2(SLOT_SIZE);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSearch = 2'd1;
  localparam logic [1:0] StGrant  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [NUM_SLOTS-1:0] used_q, used_d;
  logic [ReqW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SlotW-1:0]     next_slot_q, next_slot_d;
  logic [ReqW-1:0]      winner_q, winner_d;
  logic [SlotW-1:0]     scan_q, scan_d;
  logic [ADDR_W-1:0]    address_q, address_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 free_err_q, free_err_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 full_q, full_d;

  // Release decode
  logic [ADDR_W:0]    rel_off;
  logic [ADDR_W-1:0]  rel_idx;
  logic [SlotW-1:0]   rel_slot;
  logic               rel_ok, rel_err;

  always_comb begin
    rel_off  = {1'b0, alloc_io.free_addr} - (ADDR_W + 1)'(BASE_ADDR);
    rel_idx  = rel_off[ADDR_W-1:0] >> SlotShift;
    rel_slot = rel_idx[SlotW-1:0];
    rel_ok   = alloc_io.free_valid && !rel_off[ADDR_W]
               && ((rel_off[ADDR_W-1:0] & ADDR_W'(SLOT_SIZE - 1)) == '0)
               && (rel_idx < ADDR_W'(NUM_SLOTS))
               && used_q[rel_slot];
    rel_err  = alloc_io.free_valid && !rel_ok;
  end

  // The requester just acked still holds req for a cycle; keep it out of the next arbitration.
  logic [NUM_REQ-1:0] req_eff;
  logic [ReqW-1:0]    pick;
  logic [ReqW-1:0]    cand;
  logic               found;

  always_comb begin
    req_eff = alloc_io.req & ~ack_q;
    pick    = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef HAND_ALLOC_PRIORITY_EN
      cand = ReqW'(i);
`else
      cand = ReqW'((32'(rr_ptr_q) + i) % NUM_REQ);
`endif
      if (!found && req_eff[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  logic [SlotW-1:0] scan_inc;
  logic [ReqW-1:0]  winner_inc;
  logic             hit;

  assign scan_inc   = (scan_q == SlotW'(NUM_SLOTS - 1)) ? '0 : scan_q + SlotW'(1);
  assign winner_inc = (winner_q == ReqW'(NUM_REQ - 1)) ? '0 : winner_q + ReqW'(1);

  always_comb begin
    state_d     = state_q;
    used_d      = used_q;
    rr_ptr_d    = rr_ptr_q;
    next_slot_d = next_slot_q;
    winner_d    = winner_q;
    scan_d      = scan_q;
    address_d   = address_q;
    ack_d       = '0;
    free_err_d  = rel_err;
    hit         = 1'b0;

    case (state_q)
      StIdle: begin
        if ((req_eff != '0) && (count_q != '0)) begin
          winner_d = pick;
          scan_d   = next_slot_q;
          state_d  = StSearch;
        end
      end
      StSearch: begin
        if (!used_q[scan_q]) begin
          hit     = 1'b1;
          state_d = StGrant;
        end else begin
          scan_d = scan_inc;
        end
      end
      StGrant: begin
        ack_d[winner_q] = 1'b1;
        address_d       = ADDR_W'(BASE_ADDR) + (ADDR_W'(scan_q) << SlotShift);
`ifndef HAND_ALLOC_PRIORITY_EN
        rr_ptr_d        = winner_inc;
`endif
        next_slot_d     = scan_inc;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A hit slot is free and a released slot is used, so these never collide.
    if (rel_ok) used_d[rel_slot] = 1'b0;
    if (hit)    used_d[scan_q]   = 1'b1;

    count_d = count_q + CntW'(rel_ok) - CntW'(hit);
    full_d  = (count_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      used_q      <= '0;
      rr_ptr_q    <= '0;
      next_slot_q <= '0;
      winner_q    <= '0;
      scan_q      <= '0;
      address_q   <= '0;
      ack_q       <= '0;
      free_err_q  <= 1'b0;
      count_q     <= CntW'(NUM_SLOTS);
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      used_q      <= used_d;
      rr_ptr_q    <= rr_ptr_d;
      next_slot_q <= next_slot_d;
      winner_q    <= winner_d;
      scan_q      <= scan_d;
      address_q   <= address_d;
      ack_q       <= ack_d;
      free_err_q  <= free_err_d;
      count_q     <= count_d;
      full_q      <= full_d;
    end
  end

  assign alloc_io.ack        = ack_q;
  assign alloc_io.address    = address_q;
  assign alloc_io.free_err   = free_err_q;
  assign alloc_io.full       = full_q;
  assign alloc_io.free_count = count_q;
endmodule

// File: tb/tb_hand_allocator.sv
// Scoreboard bench for hand_allocator: a transaction-level pool model predicts every grant.
module tb_hand_allocator;
  localparam int unsigned NReq     = 4;
  localparam int unsigned NSlots   = 8;
  localparam int unsigned AddrW    = 10;
  localparam int unsigned SlotSize = 32;
  localparam int unsigned Base     = 0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hand_allocator_if #(.NUM_REQ(NReq), .NUM_SLOTS(NSlots), .ADDR_W(AddrW)) bus ();

  hand_allocator #(
    .NUM_REQ  (NReq),
    .NUM_SLOTS(NSlots),
    .ADDR_W   (AddrW),
    .SLOT_SIZE(SlotSize),
    .BASE_ADDR(Base)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .alloc_io(bus)
  );

  typedef struct {
    logic [3:0]  ack;
    int unsigned addr;
    int unsigned cnt;
    int unsigned k;
    bit          chained;
    bit          lat_chk;
    int unsigned start;
  } item_t;

  item_t       exp_q[$];
  item_t       mon_it;
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned last_ack = 0;

  // Reference pool model
  bit          m_used[NSlots];
  int unsigned m_rr, m_next, m_cnt;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NSlots; i++) m_used[i] = 1'b0;
    m_rr   = 0;
    m_next = 0;
    m_cnt  = NSlots;
  endfunction

  // Predict the grant sequence for a held request mask; each grant takes the next free slot.
  function automatic void m_batch(input logic [3:0] mask, input int unsigned start, input bit lat);
    logic [3:0]  pend;
    bit          first;
    int unsigned w, s, k;
    item_t       it;
    pend  = mask;
    first = 1'b1;
    while (pend != 4'b0) begin
`ifdef HAND_ALLOC_PRIORITY_EN
      w = 0;
`else
      w = m_rr;
`endif
      while (!pend[w]) w = (w + 1) % NReq;
      s = m_next;
      k = 1;
      while (m_used[s]) begin
        s = (s + 1) % NSlots;
        k++;
      end
      m_used[s]  = 1'b1;
      m_cnt      = m_cnt - 1;
      m_rr       = (w + 1) % NReq;
      m_next     = (s + 1) % NSlots;
      pend[w]    = 1'b0;
      it.ack     = 4'(1 << w);
      it.addr    = Base + s * SlotSize;
      it.cnt     = m_cnt;
      it.k       = k;
      it.chained = !first;
      it.lat_chk = lat;
      it.start   = start;
      exp_q.push_back(it);
      first = 1'b0;
    end
  endfunction

  function automatic bit m_release(input int unsigned a);
    int unsigned idx;
    if (a < Base || ((a - Base) % SlotSize) != 0) return 1'b1;
    idx = (a - Base) / SlotSize;
    if (idx >= NSlots || !m_used[idx]) return 1'b1;
    m_used[idx] = 1'b0;
    m_cnt       = m_cnt + 1;
    return 1'b0;
  endfunction

  // Monitor: every ack pops one expected grant
  always @(negedge clock) begin
    if (!reset && bus.ack != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", bus.ack, 0);
      end else begin
        mon_it = exp_q.pop_front();
        chk("grant_ack", bus.ack, mon_it.ack);
        chk("grant_addr", bus.address, mon_it.addr);
        chk("grant_count", bus.free_count, mon_it.cnt);
        chk("grant_full", bus.full, (mon_it.cnt == 0) ? 1 : 0);
        if (mon_it.lat_chk)
          chk("grant_latency", cyc, mon_it.chained ? last_ack + mon_it.k + 2
                                                   : mon_it.start + mon_it.k + 1);
        last_ack = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.req        = '0;
    bus.free_valid = 1'b0;
    bus.free_addr  = '0;
    tick();
    tick();
    reset = 1'b0;
    m_reset();
  endtask

  task automatic wait_grants();
    for (int n = 0; n < 200 && bus.req != 4'b0; n++) begin
      tick();
      bus.req = bus.req & ~bus.ack;
    end
    if (bus.req != 4'b0) begin
      chk("grant_timeout", bus.req, 0);
      bus.req = '0;
      exp_q.delete();
    end
    tick();
  endtask

  task automatic run_req(input logic [3:0] mask);
    m_batch(mask, cyc + 1, 1'b1);
    bus.req = mask;
    wait_grants();
  endtask

  task automatic run_rel(input int unsigned a, input string name);
    bit e;
    e              = m_release(a);
    bus.free_valid = 1'b1;
    bus.free_addr  = AddrW'(a);
    tick();
    bus.free_valid = 1'b0;
    chk({name, "_err"}, bus.free_err, e);
    chk({name, "_count"}, bus.free_count, m_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [3:0]  mask;
    int unsigned a, s;
    bit          e;

    do_reset();
    chk("reset_ack", bus.ack, 0);
    chk("reset_address", bus.address, 0);
    chk("reset_free_err", bus.free_err, 0);
    chk("reset_full", bus.full, 0);
    chk("reset_count", bus.free_count, NSlots);

    // Single request, minimum latency
    run_req(4'b0001);

    // All players at once: order 0,1,2,3
    do_reset();
    run_req(4'b1111);

    // Fill the pool, then a request must wait until a release
    run_req(4'b1111);
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.free_count, 0);
    bus.req = 4'b0010;
    repeat (12) tick();
    chk("wait_no_ack", bus.ack, 0);
    chk("wait_count", bus.free_count, 0);
    run_rel(64, "rel_64_used");
    m_batch(4'b0010, 0, 1'b0);
    wait_grants();

    // Rejected releases
    do_reset();
    run_rel(33, "rel_33");
    run_rel(256, "rel_256");
    run_rel(64, "rel_64_free");
    run_rel(1023, "rel_1023");

    // Release and request in the same cycle; search starts at the pointer
    do_reset();
    run_req(4'b0001);
    run_req(4'b0010);
    run_req(4'b0100);
    e = m_release(32);
    m_batch(4'b1000, cyc + 1, 1'b1);
    bus.req        = 4'b1000;
    bus.free_valid = 1'b1;
    bus.free_addr  = AddrW'(32);
    tick();
    bus.free_valid = 1'b0;
    chk("simul_err", bus.free_err, e);
    wait_grants();

    // Reset during search aborts the grant
    do_reset();
    run_req(4'b1111);
    run_req(4'b0111);
    bus.req = 4'b1000;
    tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    bus.req = '0;
    m_reset();
    chk("abort_ack", bus.ack, 0);
    chk("abort_count", bus.free_count, NSlots);
    chk("abort_full", bus.full, 0);
    repeat (10) tick();

    // Randomized traffic
    do_reset();
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          if (m_cnt > 0) begin
            mask = 4'($urandom_range(1, 15));
            for (int b = 0; b < 4; b++)
              if ($countones(mask) > m_cnt && mask[b]) mask[b] = 1'b0;
            run_req(mask);
          end else begin
            run_rel($urandom_range(0, 1023), "rnd_rel_any");
          end
        end
        1: begin
          s = $urandom_range(0, NSlots - 1);
          for (int n = 0; n < NSlots && !m_used[s]; n++) s = (s + 1) % NSlots;
          a = Base + s * SlotSize;
          run_rel(a, "rnd_rel_slot");
        end
        default: run_rel($urandom_range(0, 1023), "rnd_rel_any");
      endcase
    end

    repeat (5) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hand_allocator.md
# hand_allocator

Shared allocator for player hand storage. Multiple `player` instances request a hand region; the block arbitrates between them, searches a free-slot bitmap one slot per cycle, and returns the base memory address of a reserved region. It also accepts slot releases. It sits between the players and card memory as the single owner of hand-region bookkeeping.

## Interface
- `NUM_REQ`, 4: number of requesting players.
- `NUM_SLOTS`, 8: number of hand regions in the pool.
- `ADDR_W`, 10: memory address width.
- `SLOT_SIZE`, 32: words per hand region; must be a power of two.
- `BASE_ADDR`, 0: address of slot 0.

- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_REQ: per-player allocation request; the player holds it high until its `ack`.
- `ack` out NUM_REQ: one-cycle grant pulse, one-hot.
- `address` out ADDR_W: granted region base; valid only while `ack` is nonzero; holds its last value otherwise.
- `free_valid` in 1: release strobe.
- `free_addr` in ADDR_W: base address of the region to release.
- `free_err` out 1: one-cycle pulse when a release is rejected.
- `full` out 1: high when no slot is free.
- `free_count` out $clog2(NUM_SLOTS+1): number of free slots.

## Operation
- State: slot bitmap `used[NUM_SLOTS]`, round-robin pointer `rr_ptr`, search pointer `next_slot`, latched `winner`, scan index.
- FSM states and transitions:
  - IDLE → SEARCH: taken when `req` is nonzero and `free_count > 0`.
    - Latch `winner` = first asserted `req` bit at or after `rr_ptr`, scanning cyclically.
    - Load scan index = `next_slot`.
    - With `req` nonzero and `free_count == 0`, stay in IDLE; the request waits.
  - SEARCH → GRANT, on a hit: each cycle tests `used[scan]`. If clear, set it, latch `address` = BASE_ADDR + scan*SLOT_SIZE, decrement the count.
  - SEARCH → SEARCH, on a miss: scan = (scan+1) mod NUM_SLOTS. The search terminates within NUM_SLOTS cycles because free slots never disappear during a search.
  - GRANT → IDLE: pulse `ack[winner]`, set `rr_ptr` = (winner+1) mod NUM_REQ, set `next_slot` = (scan+1) mod NUM_SLOTS.
- A requester that drops `req` before `ack` is a protocol violation. The grant is still issued and the slot stays allocated.
- Release:
  - On `free_valid`, slot index = (free_addr − BASE_ADDR) >> log2(SLOT_SIZE).
  - The slot is cleared and the count incremented at the next edge.
  - Release is accepted in any FSM state.
  - Rejected (`free_err` pulse, no state change) when the address is below BASE_ADDR, the index ≥ NUM_SLOTS, the address is not SLOT_SIZE-aligned, or the slot is already free.
- Simultaneous events:
  - Release and search hit in the same cycle: the count nets to 0. Both bitmap updates apply, and they are always to different slots.
  - A slot released in cycle t becomes visible to SEARCH from cycle t+1.
- `full` = (`free_count == 0`), registered alongside the count.

## Timing
- Reset values:
  - `ack` 0, `address` 0, `free_err` 0, `full` 0, `free_count` = NUM_SLOTS.
  - All slots free; `rr_ptr` 0, `next_slot` 0; FSM in IDLE.
- Reset mid-search or mid-grant aborts the operation: no `ack` is issued and all slots are freed.
- Latency, with `req` sampled in IDLE at edge 0:
  - SEARCH occupies edges 1..k, where k = number of slots examined (1..NUM_SLOTS).
  - `ack` and `address` are visible after edge k+1.
  - Minimum is 2 cycles; maximum is NUM_SLOTS+1.
- One grant per IDLE→SEARCH→GRANT pass. Back-to-back grants are spaced at least 3 cycles apart.
- `free_err` is asserted the cycle after the offending `free_valid`.

## Configuration
- `HAND_ALLOC_PRIORITY_EN`:
  - Defined: fixed priority, lowest-index `req` wins; `rr_ptr` is neither used nor updated.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then hold `req`=0001 → `ack`=0001 two cycles after sampling, `address`=0, `free_count`=7.
- `req`=1111 held; drop each bit the cycle after its ack → grant order 0,1,2,3 at addresses 0,32,64,96 (under `HAND_ALLOC_PRIORITY_EN`, same order via fixed priority).
- Fill all 8 slots → `full`=1; a further request waits with no `ack`. `free_valid` with `free_addr`=64 → that request is then granted `address`=64.
- Release 33, 256, and an already-free 64 → `free_err` pulses each time, `free_count` unchanged.
- Slots 0–2 used and `next_slot`=3; free slot 1 and request simultaneously → grant `address`=96 (slot 3, found at the pointer), `free_count` unchanged net.
- Assert `reset` during SEARCH → no `ack`; `free_count`=8 and `full`=0 on the following cycle.
